// File: rtl/fir_frame_buffer.sv
// Purpose: packs the FIR sample stream into FRAME_LEN-sample frames using a two-bank ping-pong buffer.
// Latency: the frame is presented the cycle after its last sample is written.
// Backpressure: the input has none; a sample arriving with no free bank is dropped and flagged in overflow.
module fir_frame_buffer #(
  parameter int DATA_W     = 16,
  parameter int FRAME_LEN  = 16,
  parameter int NUM_FRAMES = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        fir_valid,
  input  logic [DATA_W-1:0]           fir_d,
  output logic                        frame_valid,
  output logic [DATA_W*FRAME_LEN-1:0] frame_data,
  input  logic                        frame_ready,
  output logic [$clog2(NUM_FRAMES)-1:0] frame_idx,
  output logic                        overflow,
  output logic                        done
);

  localparam int CNT_W  = $clog2(FRAME_LEN);
  localparam int FIDX_W = $clog2(NUM_FRAMES);

  // Two frame banks. Bank contents are never reset: a bank is only read while its full flag is set.
  logic [FRAME_LEN-1:0][DATA_W-1:0] bank_mem [2];

  logic [1:0]       full;
  logic [1:0]       full_nxt;
  logic             wr_bank;
  logic             rd_bank;
  logic [CNT_W-1:0] wr_cnt;

  logic hs;
  logic space;
  logic wr_en;
  logic drop;
  logic last_slot;

  // Handshake, space and write/drop decisions. A bank released this cycle counts as free, so the write wins.
  always_comb begin
    hs        = full[rd_bank] & frame_ready;
    space     = ~full[wr_bank] | (hs & (rd_bank == wr_bank));
    wr_en     = fir_valid & ~done & space;
    drop      = fir_valid & ~done & ~space;
    last_slot = (wr_cnt == CNT_W'(FRAME_LEN - 1));
    full_nxt  = full;
    if (hs) begin
      full_nxt[rd_bank] = 1'b0;
    end
    if (wr_en && last_slot) begin
      full_nxt[wr_bank] = 1'b1;
    end
  end

  // Sample storage: the slot write goes to the bank currently filling.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      bank_mem[wr_bank][wr_cnt] <= fir_d;
    end
  end

  // Control state: full flags, bank pointers, fill count, frame index and the sticky flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full      <= 2'b00;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_cnt    <= '0;
      frame_idx <= '0;
      overflow  <= 1'b0;
      done      <= 1'b0;
    end else begin
      full <= full_nxt;
      if (wr_en) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (last_slot) begin
          wr_bank <= ~wr_bank;
        end
      end
      if (drop) begin
        overflow <= 1'b1;
      end
      if (hs) begin
        rd_bank   <= ~rd_bank;
        frame_idx <= frame_idx + 1'b1;
        if (frame_idx == FIDX_W'(NUM_FRAMES - 1)) begin
          done <= 1'b1;
        end
      end
    end
  end

  // Output mux: only registered state feeds the frame interface; data reads as zero when nothing is presented.
  always_comb begin
    frame_valid = full[rd_bank];
    frame_data  = '0;
    if (full[rd_bank]) begin
      frame_data = bank_mem[rd_bank];
    end
  end

endmodule

// File: tb/tb_fir_frame_buffer.sv
module tb_fir_frame_buffer;

  logic         clk;
  logic         rst;
  logic         fir_valid;
  logic [15:0]  fir_d;
  logic         frame_valid;
  logic [255:0] frame_data;
  logic         frame_ready;
  logic [5:0]   frame_idx;
  logic         overflow;
  logic         done;

  int vecs;
  int errs;

  fir_frame_buffer #(.DATA_W(16), .FRAME_LEN(16), .NUM_FRAMES(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .fir_valid   (fir_valid),
    .fir_d       (fir_d),
    .frame_valid (frame_valid),
    .frame_data  (frame_data),
    .frame_ready (frame_ready),
    .frame_idx   (frame_idx),
    .overflow    (overflow),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected frame whose slot k holds base+k.
  function automatic logic [255:0] frm(input logic [15:0] base);
    logic [255:0] f;
    f = '0;
    for (int k = 0; k < 16; k++) begin
      f[k*16 +: 16] = base + 16'(k);
    end
    return f;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    vecs        = 0;
    errs        = 0;
    rst         = 1'b1;
    fir_valid   = 1'b0;
    fir_d       = '0;
    frame_ready = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    chk("reset_valid", 256'(frame_valid), 256'(0));
    chk("reset_idx",   256'(frame_idx),   256'(0));
    chk("reset_ovf",   256'(overflow),    256'(0));
    chk("reset_done",  256'(done),        256'(0));

    // Single frame with ready held high.
    frame_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      fir_valid = 1'b1;
      fir_d     = 16'(i);
      cyc();
      if (i == 15) chk("single_not_yet", 256'(frame_valid), 256'(0));
    end
    fir_valid = 1'b0;
    chk("single_valid", 256'(frame_valid), 256'(1));
    chk("single_data",  frame_data,        frm(16'h0001));
    chk("single_idx",   256'(frame_idx),   256'(0));
    cyc();
    chk("single_valid_drop", 256'(frame_valid), 256'(0));
    chk("single_idx_next",   256'(frame_idx),   256'(1));

    // Overflow: both banks fill, the rest are dropped, then back-to-back release.
    do_reset();
    frame_ready = 1'b0;
    for (int i = 1; i <= 48; i++) begin
      fir_valid = 1'b1;
      fir_d     = 16'(i);
      cyc();
      if (i == 16) chk("ovf_first_full", frame_data, frm(16'h0001));
      if (i == 32) chk("ovf_not_yet", 256'(overflow), 256'(0));
      if (i == 33) chk("ovf_set", 256'(overflow), 256'(1));
    end
    fir_valid = 1'b0;
    chk("ovf_stable_valid", 256'(frame_valid), 256'(1));
    chk("ovf_stable_data",  frame_data,        frm(16'h0001));
    chk("ovf_stable_idx",   256'(frame_idx),   256'(0));
    frame_ready = 1'b1;
    cyc();
    chk("ovf_b2b_valid", 256'(frame_valid), 256'(1));
    chk("ovf_b2b_data",  frame_data,        frm(16'h0011));
    chk("ovf_b2b_idx",   256'(frame_idx),   256'(1));
    cyc();
    chk("ovf_empty", 256'(frame_valid), 256'(0));
    chk("ovf_idx2",  256'(frame_idx),   256'(2));
    frame_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      fir_valid = 1'b1;
      fir_d     = 16'(100 + i);
      cyc();
    end
    fir_valid = 1'b1;
    chk("ovf_resume_data", frame_data,      frm(16'd100));
    chk("ovf_resume_idx",  256'(frame_idx), 256'(2));
    chk("ovf_sticky",      256'(overflow),  256'(1));

    // Asynchronous reset mid-clock while a frame is presented.
    #4;
    rst = 1'b1;
    #1;
    chk("arst_valid", 256'(frame_valid), 256'(0));
    chk("arst_data",  frame_data,        256'(0));
    chk("arst_idx",   256'(frame_idx),   256'(0));
    chk("arst_ovf",   256'(overflow),    256'(0));
    chk("arst_done",  256'(done),        256'(0));
    fir_valid = 1'b0;
    cyc();
    rst = 1'b0;

    // Release and write on the same edge.
    for (int i = 1; i <= 32; i++) begin
      fir_valid = 1'b1;
      fir_d     = 16'(i);
      cyc();
    end
    fir_d       = 16'd33;
    frame_ready = 1'b1;
    cyc();
    frame_ready = 1'b0;
    chk("sim_ovf",   256'(overflow),    256'(0));
    chk("sim_valid", 256'(frame_valid), 256'(1));
    chk("sim_data",  frame_data,        frm(16'h0011));
    chk("sim_idx",   256'(frame_idx),   256'(1));
    for (int i = 34; i <= 48; i++) begin
      fir_d = 16'(i);
      cyc();
    end
    fir_valid   = 1'b0;
    frame_ready = 1'b1;
    cyc();
    chk("sim_slot0_data", frame_data,      frm(16'd33));
    chk("sim_slot0_idx",  256'(frame_idx), 256'(2));
    chk("sim_ovf_final",  256'(overflow),  256'(0));
    cyc();

    // Gapped input.
    do_reset();
    frame_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      fir_valid = 1'b1;
      fir_d     = 16'hFF00 + 16'(i);
      cyc();
      fir_valid = 1'b0;
      chk("gap_valid", 256'(frame_valid), 256'((i % 16) == 15));
      if ((i % 16) == 15) begin
        chk("gap_data", frame_data, frm(16'hFF00 + 16'(i - 15)));
        chk("gap_idx",  256'(frame_idx), 256'(i / 16));
      end
      cyc();
      chk("gap_off", 256'(frame_valid), 256'(0));
    end

    // Full record of 64 frames.
    do_reset();
    frame_ready = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      fir_valid = 1'b1;
      fir_d     = 16'(i);
      cyc();
      if ((i % 16) == 15) begin
        chk("rec_valid", 256'(frame_valid), 256'(1));
        chk("rec_idx",   256'(frame_idx),   256'(i / 16));
        chk("rec_data",  frame_data,        frm(16'(i - 15)));
      end
    end
    fir_valid = 1'b0;
    chk("rec_done_pre", 256'(done), 256'(0));
    cyc();
    chk("rec_done",     256'(done),        256'(1));
    chk("rec_idx_wrap", 256'(frame_idx),   256'(0));
    for (int i = 0; i < 17; i++) begin
      fir_valid = 1'b1;
      fir_d     = 16'(2000 + i);
      cyc();
    end
    fir_valid = 1'b0;
    chk("post_done_ovf",   256'(overflow),    256'(0));
    chk("post_done_valid", 256'(frame_valid), 256'(0));

    // New record, interrupted by a mid-clock reset after 7 samples.
    do_reset();
    chk("new_rec_done", 256'(done), 256'(0));
    for (int i = 0; i < 7; i++) begin
      fir_valid = 1'b1;
      fir_d     = 16'(500 + i);
      cyc();
    end
    #4;
    rst = 1'b1;
    #1;
    chk("arst2_done", 256'(done), 256'(0));
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      fir_valid = 1'b1;
      fir_d     = 16'(200 + i);
      cyc();
    end
    fir_valid = 1'b0;
    chk("restart_valid", 256'(frame_valid), 256'(1));
    chk("restart_data",  frame_data,        frm(16'd200));
    chk("restart_idx",   256'(frame_idx),   256'(0));
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/fir_frame_buffer.md
Name: fir_frame_buffer

Overview:
- Consumer end of the FIR output stream: accepts the filtered sample stream (fir_valid/fir_d, one sample per cycle, no backpressure) and packs it into fixed-length frames for the downstream FFT stage.
- Ping-pong (two-bank) buffer: one bank fills while the other is presented on a valid/ready frame interface.
- Tracks frame count per record, flags dropped samples, signals record completion.

Parameters:
- DATA_W, 16, sample width (signed fixed point, 8 integer / 8 fraction bits; passed through unmodified).
- FRAME_LEN, 16, samples per frame (power of two, >=2).
- NUM_FRAMES, 64, frames per record (1024 samples / FRAME_LEN).

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- fir_valid  input  1  fir_d carries a sample this cycle
- fir_d  input  DATA_W  FIR output sample
- frame_valid  output  1  a complete frame is presented
- frame_data  output  DATA_W*FRAME_LEN  frame; slot k (first sample k=0) at bits [k*DATA_W +: DATA_W]
- frame_ready  input  1  downstream accepts the frame this cycle
- frame_idx  output  clog2(NUM_FRAMES)  index of the presented frame within the record
- overflow  output  1  sticky: at least one sample dropped
- done  output  1  sticky: NUM_FRAMES frames handed off

Behaviour:
- Reset: rst asynchronous, active-high; clock clk. All outputs 0.
- Reset also clears both bank full flags, wr_bank=0, rd_bank=0, wr_cnt=0, and the frame counter. Bank contents need not be cleared. Reset mid-frame discards any partial or pending frame.
- Write side:
  - Write on a clock edge with fir_valid=1 and done=0 when space exists.
  - Space exists when full[wr_bank]=0, or that bank is released by a handshake in the same cycle (write wins; no overflow).
  - Sample is stored in bank wr_bank, slot wr_cnt; wr_cnt increments.
  - At wr_cnt=FRAME_LEN-1: set full[wr_bank], toggle wr_bank, wr_cnt wraps to 0.
  - Gaps in fir_valid pause filling; no timeout; a partial frame is held indefinitely.
- Drop: fir_valid=1, done=0 and no space -> sample discarded, wr_cnt unchanged, overflow set (sticky until rst).
- After done=1: fir_valid is ignored. Not counted as overflow; no writes.
- Read side:
  - frame_valid = full[rd_bank].
  - frame_data = contents of bank rd_bank.
  - Both are driven from registers through the bank mux only; no combinational path from fir_* inputs.
  - Latency: edge writing slot FRAME_LEN-1 -> frame_valid high in the immediately following cycle.
  - Handshake = frame_valid & frame_ready at a clock edge. Effects: clear full[rd_bank], toggle rd_bank, frame_idx increments (wraps to 0 after NUM_FRAMES-1).
  - If the other bank is already full, frame_valid stays high with the next frame (back-to-back transfer, one frame per cycle).
  - frame_data and frame_valid stay stable while frame_valid=1 and frame_ready=0.
  - frame_ready while frame_valid=0 has no effect.
- done: set on the handshake of the frame with frame_idx=NUM_FRAMES-1 (high from the next cycle); cleared only by rst.
- Ordering: frames are delivered strictly in arrival order; samples within a frame are in arrival order.
- Arithmetic: counters only.
  - wr_cnt: clog2(FRAME_LEN) bits.
  - Frame counter: clog2(NUM_FRAMES) bits, natural wrap.
  - No arithmetic on sample data.

Test Plan:
- Reset: assert rst mid-clock with fir_valid=1 -> frame_valid, frame_data, frame_idx, overflow, done all 0 immediately, no clock needed.
- Single frame: frame_ready=1; fir_d=0x0001..0x0010 on 16 consecutive cycles -> frame_valid high exactly 1 cycle, starting the cycle after the 16th write. frame_data[15:0]=0x0001, [255:240]=0x0010, frame_idx=0. Next cycle frame_valid=0, frame_idx=1.
- Overflow: frame_ready=0; 48 continuous samples 1..48 -> banks full after samples 16 and 32, sample 33 dropped, overflow=1 from the cycle after. Then raise ready: frames 1..16 (idx 0) then 17..32 (idx 1) back-to-back. Samples 34..48 are also dropped (both banks full); after release, filling resumes at slot 0.
- Simultaneous release/write: frame_ready=0 through sample 32; sample 33 and frame_ready=1 on the same cycle -> no overflow, sample 33 lands in bank 0 slot 0. Frame 17..32 presented next cycle.
- Gapped input: fir_valid toggling 1/0 for 32 valid samples 0xFF00..0xFF1F -> frames identical to the contiguous case (0xFF00..0xFF0F, 0xFF10..0xFF1F); frame_valid rises the cycle after each 16th valid.
- Full record: 1024 continuous samples, frame_ready=1 -> 64 frames, frame_idx 0..63 in order. done=1 the cycle after frame 63 handshake. Sample 1025 ignored; overflow stays 0. Reset after 7 samples of a new record -> next frame starts at slot 0.
